// File: rtl/regspace_pkg.sv
// Shared definitions for the register-space arbiter: command encoding,
// ack-state enum and default geometry.
package regspace_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    A_DONE  = 2'd1,
    B_DONE  = 2'd2,
    AB_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regspace_ram.sv
// 2**AW x DW synchronous array, one access port (write and read share the
// address), with registered read-out. Contents are never reset.
module regspace_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Read captures the pre-write word when a write lands at the same edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/regspace_arbiter.sv
// Two-port arbiter (A over B) in front of the 256x16 configuration array.
// Optional macro COL_CNT_EN adds a saturating collision counter output col_cnt.
module regspace_arbiter
  import regspace_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_cmd,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_cmd,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          col_pulse,
  output state_e        dbg_state_o
`ifdef COL_CNT_EN
  ,
  output logic [7:0]    col_cnt
`endif
);

  // Handshake: a requester holds req/cmd/addr/wdata stable until it sees a
  // one-cycle ack; req is ignored during its own ack cycle, and a new request
  // may follow in the next cycle. rdata is valid with a read ack and held.
  state_e        state_q, state_d;
  logic          elig_a, elig_b, collide;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic [DW-1:0] a_hold_q, b_hold_q;

  always_comb begin
    elig_a    = a_req && !(state_q == A_DONE || state_q == AB_DONE);
    elig_b    = b_req && !(state_q == B_DONE || state_q == AB_DONE);
    collide   = elig_a && elig_b && (a_cmd == CMD_WRITE) && (b_cmd == CMD_WRITE)
                && (a_addr == b_addr);
    state_d   = IDLE;
    ram_we    = 1'b0;
    ram_addr  = a_addr;
    ram_wdata = a_wdata;
    a_rd_d    = 1'b0;
    b_rd_d    = 1'b0;
    if (elig_a) begin
      ram_we  = (a_cmd == CMD_WRITE);
      a_rd_d  = (a_cmd == CMD_READ);
      state_d = collide ? AB_DONE : A_DONE;
    end else if (elig_b) begin
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
      ram_we    = (b_cmd == CMD_WRITE);
      b_rd_d    = (b_cmd == CMD_READ);
      state_d   = B_DONE;
    end
  end

  // Reset wins over any write granted at the same edge.
  regspace_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we && !reset),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_rd_q   <= 1'b0;
      b_rd_q   <= 1'b0;
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      a_rd_q   <= a_rd_d;
      b_rd_q   <= b_rd_d;
      a_hold_q <= a_rdata;
      b_hold_q <= b_rdata;
    end
  end

  // The shared RAM read register is only meaningful in a read's ack cycle;
  // otherwise each port shows its own last read word.
  assign a_rdata     = a_rd_q ? ram_rdata : a_hold_q;
  assign b_rdata     = b_rd_q ? ram_rdata : b_hold_q;
  assign a_ack       = (state_q == A_DONE) || (state_q == AB_DONE);
  assign b_ack       = (state_q == B_DONE) || (state_q == AB_DONE);
  assign col_pulse   = (state_q == AB_DONE);
  assign dbg_state_o = state_q;

`ifdef COL_CNT_EN
  logic [7:0] col_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) col_cnt_q <= 8'd0;
    else if (col_pulse && col_cnt_q != 8'hFF) col_cnt_q <= col_cnt_q + 8'd1;
  end

  assign col_cnt = col_cnt_q;
`endif

endmodule

// File: tb/tb_regspace_arbiter.sv
// Randomized and directed bench for regspace_arbiter against a transaction
// model (memory array + per-port read queues); optional COL_CNT_EN checks.
module tb_regspace_arbiter;
  import regspace_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_cmd = 1'b0, b_req = 1'b0, b_cmd = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ack, b_ack, col_pulse;
  logic [DW-1:0] a_rdata, b_rdata;
  state_e        dbg_state;
`ifdef COL_CNT_EN
  logic [7:0]    col_cnt;
`endif

  regspace_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .col_pulse(col_pulse), .dbg_state_o(dbg_state)
`ifdef COL_CNT_EN
    , .col_cnt(col_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model state
  int            checks = 0, errors = 0;
  logic [DW-1:0] mem_m [2**AW];
  logic [DW-1:0] a_exp_q[$], b_exp_q[$];
  logic          exp_a_ack = 1'b0, exp_b_ack = 1'b0, exp_col = 1'b0;
  logic [DW-1:0] exp_a_rdata = '0, exp_b_rdata = '0;
  int            exp_cnt = 0;
  int            a_wait = 0, b_wait = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply the access rules to the current inputs, advance, compare.
  task automatic step();
    logic ea, eb, na, nb, nc, ard, brd;
    na = 1'b0; nb = 1'b0; nc = 1'b0; ard = 1'b0; brd = 1'b0;
    if (!reset) begin
      ea = a_req && !exp_a_ack;
      eb = b_req && !exp_b_ack;
      if (ea && eb && a_cmd && b_cmd && a_addr == b_addr) begin
        mem_m[a_addr] = a_wdata;
        na = 1'b1; nb = 1'b1; nc = 1'b1;
      end else if (ea) begin
        na = 1'b1;
        if (a_cmd) mem_m[a_addr] = a_wdata;
        else begin a_exp_q.push_back(mem_m[a_addr]); ard = 1'b1; end
      end else if (eb) begin
        nb = 1'b1;
        if (b_cmd) mem_m[b_addr] = b_wdata;
        else begin b_exp_q.push_back(mem_m[b_addr]); brd = 1'b1; end
      end
    end
    if (reset) exp_cnt = 0;
    else if (exp_col && exp_cnt < 255) exp_cnt++;
    @(posedge clk);
    exp_a_ack = na; exp_b_ack = nb; exp_col = nc;
    if (reset) begin exp_a_rdata = '0; exp_b_rdata = '0; end
    if (ard) exp_a_rdata = a_exp_q.pop_front();
    if (brd) exp_b_rdata = b_exp_q.pop_front();
    @(negedge clk);
    check("a_ack", a_ack, exp_a_ack);
    check("b_ack", b_ack, exp_b_ack);
    check("col_pulse", col_pulse, exp_col);
    check("a_rdata", a_rdata, exp_a_rdata);
    check("b_rdata", b_rdata, exp_b_rdata);
`ifdef COL_CNT_EN
    check("col_cnt", col_cnt, exp_cnt);
`endif
  endtask

  // driver tasks
  task automatic single(input bit on_b, input logic cmd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output logic [DW-1:0] rd);
    int lat = 0;
    bit done = 0;
    if (on_b) begin b_req = 1; b_cmd = cmd; b_addr = addr; b_wdata = data; end
    else      begin a_req = 1; a_cmd = cmd; a_addr = addr; a_wdata = data; end
    while (!done && lat < 6) begin
      step();
      lat++;
      done = on_b ? b_ack : a_ack;
    end
    check(on_b ? "b_single_lat" : "a_single_lat", lat, 1);
    rd = on_b ? b_rdata : a_rdata;
    a_req = 0; b_req = 0;
    step();
  endtask

  task automatic both(input logic ac, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bc, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      output int la, output int lb, output bit col_seen);
    bit da = 0, db = 0;
    la = 0; lb = 0; col_seen = 0;
    a_req = 1; a_cmd = ac; a_addr = aa; a_wdata = ad;
    b_req = 1; b_cmd = bc; b_addr = ba; b_wdata = bd;
    for (int i = 0; i < 8 && !(da && db); i++) begin
      step();
      if (!da) la++;
      if (!db) lb++;
      if (col_pulse) col_seen = 1;
      if (a_ack && !da) begin da = 1; a_req = 0; end
      if (b_ack && !db) begin db = 1; b_req = 0; end
    end
    a_req = 0; b_req = 0;
    step();
  endtask

  task automatic run_rand(input int n, input int pa, input int pb, input int amax);
    for (int c = 0; c < n + 12; c++) begin
      if (exp_a_ack) a_req = 0;
      else if (!a_req && c < n && int'($urandom_range(99)) < pa) begin
        a_req = 1; a_cmd = 1'($urandom_range(1));
        a_addr = AW'($urandom_range(amax)); a_wdata = DW'($urandom);
      end
      if (exp_b_ack) b_req = 0;
      else if (!b_req && c < n && int'($urandom_range(99)) < pb) begin
        b_req = 1; b_cmd = 1'($urandom_range(1));
        b_addr = AW'($urandom_range(amax)); b_wdata = DW'($urandom);
      end
      if (a_req) a_wait++;
      if (b_req) b_wait++;
      step();
      if (a_ack) begin check("a_lat", a_wait, 1); a_wait = 0; end
      if (b_ack) begin check("b_lat_le2", (b_wait <= 2), 1); b_wait = 0; end
      else if (b_wait > 2) begin check("b_wait_bound", b_wait, 2); b_wait = 0; end
    end
    a_req = 0; b_req = 0; a_wait = 0; b_wait = 0;
    step();
  endtask

  // main sequence
  initial begin
    logic [DW-1:0] rd;
    int la, lb;
    bit col;

    reset = 1;
    step(); step();
    check("rst_state", dbg_state, IDLE);
    check("rst_a_rdata", a_rdata, 0);
    reset = 0;
    step();

    for (int i = 0; i < 2**AW; i++) single(0, CMD_WRITE, AW'(i), DW'($urandom), rd);
    single(0, CMD_WRITE, 8'h20, 16'h1234, rd);
    single(0, CMD_WRITE, 8'h30, 16'h3030, rd);

    single(0, CMD_WRITE, 8'h10, 16'hBEEF, rd);
    single(0, CMD_READ, 8'h10, 16'h0000, rd);
    check("a_read_beef", rd, 16'hBEEF);

    both(CMD_READ, 8'h20, 0, CMD_READ, 8'h20, 0, la, lb, col);
    check("rr_a_lat", la, 1);
    check("rr_b_lat", lb, 2);
    check("rr_a_rdata", a_rdata, 16'h1234);
    check("rr_b_rdata", b_rdata, 16'h1234);

    both(CMD_WRITE, 8'h05, 16'hAAAA, CMD_WRITE, 8'h05, 16'h5555, la, lb, col);
    check("col_a_lat", la, 1);
    check("col_b_lat", lb, 1);
    check("col_seen", col, 1);
    single(1, CMD_READ, 8'h05, 0, rd);
    check("col_readback", rd, 16'hAAAA);

    both(CMD_WRITE, 8'h01, 16'h1111, CMD_WRITE, 8'h02, 16'h2222, la, lb, col);
    check("diff_b_lat", lb, 2);
    check("diff_no_col", col, 0);
    single(1, CMD_READ, 8'h01, 0, rd);
    check("diff_rd01", rd, 16'h1111);
    single(0, CMD_READ, 8'h02, 0, rd);
    check("diff_rd02", rd, 16'h2222);

    // A re-requests every time it may; B must still get through
    run_rand(40, 100, 100, 255);
    run_rand(1500, 60, 60, 7);

    // reset lands on the edge an A write is eligible
    a_req = 1; a_cmd = CMD_WRITE; a_addr = 8'h30; a_wdata = 16'hDEAD;
    reset = 1;
    step();
    reset = 0; a_req = 0;
    step();
    check("rst_no_ack", a_ack, 0);
    single(0, CMD_READ, 8'h30, 0, rd);
    check("rst_write_dropped", rd, 16'h3030);

`ifdef COL_CNT_EN
    for (int k = 0; k < 300; k++)
      both(CMD_WRITE, AW'(k), DW'($urandom), CMD_WRITE, AW'(k), DW'($urandom), la, lb, col);
    check("col_cnt_sat", col_cnt, 255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
